// File: rtl/ddr_device_model.sv
// ddr_device_model
//   Memory-device end of the DDR command/data link. Decodes RAS#/CAS#/WE#
//   commands, keeps an open flag and a latched row per bank, and stores or
//   returns one fixed-length burst at a time. READ data is driven on DQ
//   CAS_LATENCY cycles after the command. WRITE data is sampled WRITE_LATENCY
//   cycles after the command. Protocol violations set sticky error flags, and
//   the offending command is ignored.
//
//   Timing reference: "cycle k" is the value present at rising edge k. A
//   command sampled at edge T has its first read beat on the bus at edge
//   T+CL, so the DQ output register is loaded at edge T+CL-1.
//
// Ports
//   mem_clk    in     1   clock, everything sampled/driven on the rising edge
//   mem_rst_n  in     1   asynchronous active-low reset
//   ddr_addr   in    14   row (ACT), column (RD/WR), bit 10 = all banks (PRE)
//   ddr_ba     in     3   bank address
//   ddr_ras_n  in     1   command strobe, active low
//   ddr_cas_n  in     1   command strobe, active low
//   ddr_we_n   in     1   command strobe, active low
//   ddr_dq     inout 16   data, driven only during read beats
//   busy       out    1   a burst is pending or in progress
//   err_flags  out    4   sticky errors: [0] RD/WR to closed bank,
//                         [1] ACT to open bank, [2] RD/WR while busy,
//                         [3] REF with a bank open
//   err_clr    in     1   synchronous clear of err_flags, beats new errors
module ddr_device_model #(
    parameter int ROW_BITS      = 4,
    parameter int COL_BITS      = 6,
    parameter int BURST_LENGTH  = 8,
    parameter int CAS_LATENCY   = 3,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        mem_clk,
    input  logic        mem_rst_n,
    input  logic [13:0] ddr_addr,
    input  logic [2:0]  ddr_ba,
    input  logic        ddr_ras_n,
    input  logic        ddr_cas_n,
    input  logic        ddr_we_n,
    inout  wire  [15:0] ddr_dq,
    output logic        busy,
    output logic [3:0]  err_flags,
    input  logic        err_clr
);

    localparam int AW    = 3 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = 8;

    // Cycle offsets (relative to the command edge) of the first and last beats.
    localparam logic [CW-1:0] RD_FIRST = CW'(CAS_LATENCY);
    localparam logic [CW-1:0] RD_LAST  = CW'(CAS_LATENCY + BURST_LENGTH - 1);
    localparam logic [CW-1:0] WR_FIRST = CW'(WRITE_LATENCY);
    localparam logic [CW-1:0] WR_LAST  = CW'(WRITE_LATENCY + BURST_LENGTH - 1);
    localparam logic [COL_BITS-1:0] WRAP_MASK = COL_BITS'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_READ  = 2'd1,
        ENG_WRITE = 2'd2
    } eng_state_e;

    // Column of burst beat 'beat': the low log2(BL) bits wrap inside the
    // aligned burst, and the upper column bits stay fixed.
    function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] col,
                                                     input logic [CW-1:0]       beat);
        logic [COL_BITS-1:0] sum;
        sum = col + COL_BITS'(beat);
        return (col & ~WRAP_MASK) | (sum & WRAP_MASK);
    endfunction

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [2:0]          cmd;
    logic                cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;
    logic                unused_addr_bits;

    assign cmd     = {ddr_ras_n, ddr_cas_n, ddr_we_n};
    assign cmd_act = (cmd == 3'b011);
    assign cmd_rd  = (cmd == 3'b101);
    assign cmd_wr  = (cmd == 3'b100);
    assign cmd_pre = (cmd == 3'b010);
    assign cmd_ref = (cmd == 3'b001);
    assign cmd_row = ddr_addr[ROW_BITS-1:0];
    assign cmd_col = ddr_addr[COL_BITS-1:0];
    // Upper address bits alias; they are deliberately ignored.
    assign unused_addr_bits = ^ddr_addr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]          open_q, open_d;
    logic [ROW_BITS-1:0] row_q [8];
    logic [ROW_BITS-1:0] row_d [8];
    eng_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          eb_q, eb_d;
    logic [ROW_BITS-1:0] er_q, er_d;
    logic [COL_BITS-1:0] ec_q, ec_d;
    logic                oe_q, oe_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic [3:0]          err_q, err_d;
    logic [15:0]         mem_q [DEPTH];

    logic busy_w, bank_open, start_rd, start_wr;
    logic err_closed, err_open, err_busy, err_ref;

    assign busy_w    = (state_q != ENG_IDLE);
    assign bank_open = open_q[ddr_ba];

    assign err_closed = (cmd_rd | cmd_wr) & ~bank_open;
    assign err_busy   = (cmd_rd | cmd_wr) & busy_w;
    assign err_open   = cmd_act & bank_open;
    assign err_ref    = cmd_ref & (|open_q);

    // A burst starts only when the command is fully legal.
    assign start_rd = cmd_rd & bank_open & ~busy_w;
    assign start_wr = cmd_wr & bank_open & ~busy_w;

    // ------------------------------------------------------------------
    // Bank open/row tracking
    // ------------------------------------------------------------------
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (cmd_act && !bank_open) begin
            open_d[ddr_ba] = 1'b1;
            row_d[ddr_ba]  = cmd_row;
        end
        if (cmd_pre) begin
            if (ddr_addr[10]) begin
                open_d = '0;
            end else begin
                open_d[ddr_ba] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data engine FSM. cnt_q holds the cycle offset from the command edge,
    // so the burst address (bank/row/col) is latched once and a later PRE
    // cannot disturb it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eb_d    = eb_q;
        er_d    = er_q;
        ec_d    = ec_q;
        case (state_q)
            ENG_IDLE: begin
                if (start_rd || start_wr) begin
                    state_d = start_rd ? ENG_READ : ENG_WRITE;
                    cnt_d   = 8'd1;
                    eb_d    = ddr_ba;
                    er_d    = row_q[ddr_ba];
                    ec_d    = cmd_col;
                end
            end
            ENG_READ: begin
                if (cnt_q == RD_LAST) begin
                    state_d = ENG_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ENG_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = ENG_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ENG_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path: the output register is loaded one edge before the beat
    // cycle. With CL=1 that edge is the command edge itself, so the
    // address comes straight from the command rather than the latches.
    // ------------------------------------------------------------------
    logic [CW-1:0]       off_n;
    logic [2:0]          rd_bank;
    logic [ROW_BITS-1:0] rd_row;
    logic [COL_BITS-1:0] rd_col;
    logic [AW-1:0]       rd_addr;

    always_comb begin
        off_n    = (state_q == ENG_IDLE) ? 8'd1 : cnt_q + 8'd1;
        rd_bank  = start_rd ? ddr_ba         : eb_q;
        rd_row   = start_rd ? row_q[ddr_ba]  : er_q;
        rd_col   = start_rd ? cmd_col        : ec_q;
        oe_d     = (start_rd || (state_q == ENG_READ)) &&
                   (off_n >= RD_FIRST) && (off_n <= RD_LAST);
        rd_addr  = {rd_bank, rd_row, beat_col(rd_col, off_n - RD_FIRST)};
        dq_out_d = oe_d ? mem_q[rd_addr] : dq_out_q;
    end

    assign ddr_dq = oe_q ? dq_out_q : 16'hzzzz;

    // ------------------------------------------------------------------
    // Write path: beats are sampled at offsets WL .. WL+BL-1.
    // ------------------------------------------------------------------
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign wr_en   = (state_q == ENG_WRITE) && (cnt_q >= WR_FIRST);
    assign wr_addr = {eb_q, er_q, beat_col(ec_q, cnt_q - WR_FIRST)};

    // Storage array is intentionally not reset.
    always_ff @(posedge mem_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= ddr_dq;
        end
    end

    // ------------------------------------------------------------------
    // Error flags: err_clr has priority over errors raised in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q | {err_ref, err_busy, err_open, err_closed};
        if (err_clr) begin
            err_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            open_q   <= '0;
            for (int b = 0; b < 8; b++) begin
                row_q[b] <= '0;
            end
            state_q  <= ENG_IDLE;
            cnt_q    <= '0;
            eb_q     <= '0;
            er_q     <= '0;
            ec_q     <= '0;
            oe_q     <= 1'b0;
            dq_out_q <= '0;
            err_q    <= '0;
        end else begin
            open_q   <= open_d;
            row_q    <= row_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eb_q     <= eb_d;
            er_q     <= er_d;
            ec_q     <= ec_d;
            oe_q     <= oe_d;
            dq_out_q <= dq_out_d;
            err_q    <= err_d;
        end
    end

    assign busy      = busy_w;
    assign err_flags = err_q;

endmodule
